// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-ported memory between instruction fetch and
//            the load/store path. Only one transaction is outstanding at a
//            time: grant a requester, drive the memory port until it is
//            accepted, wait for the response, then return the read data to
//            the requester that owns the transaction. Also produces the
//            pipeline stall for pending data accesses.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W           address width
//   DATA_W           data width (byte enables are DATA_W/8 bits)
//   MAX_DATA_STREAK  consecutive data grants allowed while fetch waits
//                    (only used with MEM_ARB_FAIRNESS_EN, must be >= 1)
// Build option
//   MEM_ARB_FAIRNESS_EN  when defined, a saturating streak counter lets fetch
//                        win after MAX_DATA_STREAK data grants in a row made
//                        while fetch was waiting. Undefined: strict data
//                        priority.
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   if_req/if_addr                  fetch request (always a full-word read)
//   if_gnt/if_rvalid/if_rdata       fetch grant pulse, response pulse, data
//   d_req/d_we/d_addr/d_wdata/d_be  data request
//   d_gnt/d_rvalid/d_rdata          data grant pulse, response pulse, data
//   m_req/m_we/m_addr/m_wdata/m_be  memory request (registered)
//   m_ready                         memory accepts when m_req && m_ready
//   m_rvalid/m_rdata                memory response strobe and data
//   stall                           hold fetch/decode for data accesses
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  // load/store
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // memory port
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  // pipeline control
  output logic                stall
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   owner_data;   // 0: fetch owns the transaction, 1: data owns it
  logic   fetch_pri;    // fetch overrides data priority this arbitration
  logic   grant_d;
  logic   grant_f;

`ifdef MEM_ARB_FAIRNESS_EN
  // +2 keeps the counter at least one bit wide and able to hold the maximum.
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 2);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] streak;

  assign fetch_pri = if_req && (streak == STREAK_MAX);

  // Counts data grants made while fetch is waiting; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (grant_f) begin
      streak <= '0;
    end else if (grant_d) begin
      if (!if_req) begin
        streak <= '0;
      end else if (streak != STREAK_MAX) begin
        streak <= streak + 1'b1;
      end
    end
  end
`else
  // Strict data priority. The streak limit only matters in the fairness
  // build; this term is constant false and keeps the parameter referenced.
  assign fetch_pri = (MAX_DATA_STREAK < 0) && if_req;
`endif

  // Arbitration happens only in IDLE; grants are suppressed during reset so
  // a requester never sees a grant that the state machine does not take.
  assign grant_d = (state == IDLE) && !rst && d_req && !fetch_pri;
  assign grant_f = (state == IDLE) && !rst && if_req && !grant_d;

  assign d_gnt  = grant_d;
  assign if_gnt = grant_f;

  assign stall = d_req | ((state != IDLE) & owner_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_data <= 1'b0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_be       <= '0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= REQ;
            owner_data <= 1'b1;
            m_req      <= 1'b1;
            m_we       <= d_we;
            m_addr     <= d_addr;
            m_wdata    <= d_wdata;
            m_be       <= d_be;
          end else if (grant_f) begin
            state      <= REQ;
            owner_data <= 1'b0;
            m_req      <= 1'b1;
            m_we       <= 1'b0;
            m_addr     <= if_addr;
            m_wdata    <= '0;
            m_be       <= {BE_W{1'b1}};
          end
        end

        REQ: begin
          // Captured m_* stay stable until the memory accepts.
          if (m_ready) begin
            m_req <= 1'b0;
            state <= RESP;
          end
        end

        RESP: begin
          if (m_rvalid) begin
            state <= IDLE;
            if (owner_data) begin
              d_rvalid <= 1'b1;
              // A write response carries no load data, so the last load
              // value is kept for the pipeline.
              if (!m_we) begin
                d_rdata <= m_rdata;
              end
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= m_rdata;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A memory model answers
//            accepted requests; a scoreboard queues the expected response on
//            every grant and compares it when the matching rvalid appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_be;
  logic          m_ready;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;
  logic          stall;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_be(m_be), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
  endfunction

  // ---------------- memory model ----------------
  int          cfg_wait = 0;   // cycles m_ready stays low after m_req rises
  int          cfg_rsp  = 0;   // extra cycles between accept and m_rvalid
  int          wait_ctr = 0;
  int          rsp_ctr  = 0;
  bit          pending  = 0;
  bit          late_seen = 0;
  logic        prev_req = 1'b0;
  logic [31:0] lat_addr = '0;
  logic        lat_we   = 1'b0;

  initial begin
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    forever begin
      @(negedge clk);
      m_rvalid = 1'b0;
      if (prev_req && m_ready) begin
        pending  = 1;
        rsp_ctr  = cfg_rsp;
        lat_addr = m_addr;
        lat_we   = m_we;
      end
      if (pending) begin
        if (rsp_ctr == 0) begin
          m_rvalid  = 1'b1;
          m_rdata   = lat_we ? 32'hBAD0_BAD0 : rd_model(lat_addr);
          pending   = 0;
          late_seen = 1;
        end else begin
          rsp_ctr--;
        end
      end
      if (m_req) begin
        if (wait_ctr >= cfg_wait) begin
          m_ready = 1'b1;
        end else begin
          m_ready = 1'b0;
          wait_ctr++;
        end
      end else begin
        wait_ctr = 0;
        m_ready  = (cfg_wait == 0);
      end
      prev_req = m_req;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] last_if = '0;
  logic [31:0] last_d  = '0;

  always @(negedge clk) begin
    #2;
    if (if_rvalid) begin
      if (sb.size() == 0) begin
        chk("if_rvalid_unexpected", 32'(if_rvalid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_if_owner", 32'(mon_e.is_data), 32'd0);
        chk("sb_if_rdata", if_rdata, mon_e.data);
        last_if = mon_e.data;
      end
    end
    if (d_rvalid) begin
      if (sb.size() == 0) begin
        chk("d_rvalid_unexpected", 32'(d_rvalid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_d_owner", 32'(mon_e.is_data), 32'd1);
        if (mon_e.we) begin
          chk("sb_d_rdata_after_wr", d_rdata, last_d);
        end else begin
          chk("sb_d_rdata", d_rdata, mon_e.data);
          last_d = mon_e.data;
        end
      end
    end
    if (if_gnt) sb.push_back('{is_data: 1'b0, we: 1'b0, data: rd_model(if_addr)});
    if (d_gnt)  sb.push_back('{is_data: 1'b1, we: d_we, data: d_we ? 32'h0 : rd_model(d_addr)});
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int  k;
  int  gcount;
  logic exp_fetch;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;

    // Reset values; a fetch request during reset must not be granted.
    repeat (2) @(negedge clk);
    @(negedge clk); if_req = 1'b1; #2;
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_m_be", 32'(m_be), 32'h0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk); rst = 1'b0; if_req = 1'b0;

    // Single fetch at zero wait.
    @(negedge clk); if_req = 1'b1; if_addr = 32'h100; #2;
    chk("f_if_gnt_c0", 32'(if_gnt), 32'd1);
    chk("f_d_gnt_c0", 32'(d_gnt), 32'd0);
    chk("f_stall_c0", 32'(stall), 32'd0);
    @(negedge clk); if_req = 1'b0; if_addr = 32'hFFFF_FFFF; #2;
    chk("f_m_req_c1", 32'(m_req), 32'd1);
    chk("f_m_addr_c1", m_addr, 32'h100);
    chk("f_m_we_c1", 32'(m_we), 32'd0);
    chk("f_m_be_c1", 32'(m_be), 32'hF);
    @(negedge clk); #2;
    chk("f_m_req_c2", 32'(m_req), 32'd0);
    chk("f_if_rvalid_c2", 32'(if_rvalid), 32'd0);
    @(negedge clk); #2;
    chk("f_if_rvalid_c3", 32'(if_rvalid), 32'd1);
    chk("f_if_rdata_c3", if_rdata, 32'h13);
    cfg_wait = 2;

    // Store with two wait cycles on m_ready.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3; #2;
    chk("st_d_gnt", 32'(d_gnt), 32'd1);
    chk("st_stall_c0", 32'(stall), 32'd1);
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #2;
      chk("st_m_req_hold", 32'(m_req), 32'd1);
      chk("st_m_we_hold", 32'(m_we), 32'd1);
      chk("st_m_addr_hold", m_addr, 32'h2004);
      chk("st_m_wdata_hold", m_wdata, 32'hDEAD_BEEF);
      chk("st_m_be_hold", 32'(m_be), 32'h3);
      chk("st_stall_hold", 32'(stall), 32'd1);
    end
    for (k = 0; k < 10; k++) begin
      @(negedge clk); #2;
      if (d_rvalid) break;
      chk("st_stall_wait", 32'(stall), 32'd1);
    end
    chk("st_rvalid_latency", 32'(k), 32'd1);
    chk("st_d_rdata_kept", d_rdata, 32'h0);
    chk("st_stall_done", 32'(stall), 32'd0);
    cfg_wait = 0;

    // Simultaneous requests: data first, fetch granted in the d_rvalid cycle.
    @(negedge clk);
    d_req = 1'b1; if_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; if_addr = 32'h400; #2;
    chk("sim_d_gnt", 32'(d_gnt), 32'd1);
    chk("sim_if_gnt_c0", 32'(if_gnt), 32'd0);
    @(negedge clk); d_req = 1'b0; #2;
    chk("sim_if_gnt_c1", 32'(if_gnt), 32'd0);
    for (k = 0; k < 10; k++) begin
      @(negedge clk); #2;
      if (d_rvalid) break;
      chk("sim_if_gnt_wait", 32'(if_gnt), 32'd0);
    end
    chk("sim_d_latency", 32'(k), 32'd1);
    chk("sim_if_gnt_at_rvalid", 32'(if_gnt), 32'd1);
    chk("sim_d_rdata", d_rdata, 32'h0300_FCFF);
    @(negedge clk); if_req = 1'b0;
    for (k = 1; k <= 8; k++) begin
      #2;
      if (if_rvalid) break;
      @(negedge clk);
    end
    chk("sim_if_latency", 32'(k), 32'd3);
    chk("sim_if_rdata", if_rdata, 32'h0400_FBFF);
    cfg_rsp = 4;

    // Reset while in RESP; the late memory response must be ignored.
    @(negedge clk); if_req = 1'b1; if_addr = 32'h40; #2;
    chk("rr_if_gnt", 32'(if_gnt), 32'd1);
    @(negedge clk); if_req = 1'b0; #2;
    chk("rr_m_req", 32'(m_req), 32'd1);
    @(negedge clk); rst = 1'b1; late_seen = 0; #2;
    chk("rr_resp_m_req", 32'(m_req), 32'd0);
    @(negedge clk); rst = 1'b0; sb.delete(); last_if = '0; last_d = '0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      #2;
      chk("rr_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rr_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("rr_m_req", 32'(m_req), 32'd0);
      chk("rr_m_addr", m_addr, 32'h0);
      chk("rr_m_be", 32'(m_be), 32'h0);
      chk("rr_if_rdata", if_rdata, 32'h0);
      chk("rr_d_rdata", d_rdata, 32'h0);
      chk("rr_stall", 32'(stall), 32'd0);
    end
    chk("rr_late_rvalid_sent", 32'(late_seen), 32'd1);
    cfg_rsp = 0;

    // Both requesters held continuously.
    @(negedge clk);
    d_req = 1'b1; if_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; if_addr = 32'h600;
    gcount = 0;
    for (int c = 0; c < 100 && gcount < 15; c++) begin
      #2;
      if (if_gnt || d_gnt) begin
`ifdef MEM_ARB_FAIRNESS_EN
        exp_fetch = ((gcount % 5) == 4);
`else
        exp_fetch = 1'b0;
`endif
        chk("fair_is_fetch", 32'(if_gnt), 32'(exp_fetch));
        gcount++;
      end
      @(negedge clk);
    end
    d_req = 1'b0; if_req = 1'b0;
    chk("fair_grant_count", 32'(gcount), 32'd15);
    repeat (10) @(negedge clk);
    #2;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single-ported memory between instruction fetch and the load/store path driven by the decoded `memr`/`memw`/`memt` signals. One transaction is outstanding at a time: the block grants a requester, drives the memory port, waits for the response, and routes the read data back. It also produces the `stall` that holds fetch/decode while a data access is pending.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte enables are `DATA_W/8` bits wide.
- `MAX_DATA_STREAK`, default 4: consecutive data grants allowed while fetch waits. Used only with `MEM_ARB_FAIRNESS_EN`.

Ports:
- `clk`  in  1  clock, all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch address. Fetch is always a full-word read.
- `if_gnt`  out  1  one-cycle pulse; request captured.
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` valid.
- `if_rdata`  out  DATA_W  fetch data.
- `d_req`, `d_we`  in  1 each  data request; write when `d_we`=1. Held until `d_gnt`.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  data write value.
- `d_be`  in  DATA_W/8  data byte enables.
- `d_gnt`, `d_rvalid`  out  1 each  same meaning as the fetch versions. `d_rvalid` also fires for writes.
- `d_rdata`  out  DATA_W  load data.
- `m_req`, `m_we`  out  1 each  memory request; write when `m_we`=1.
- `m_addr`  out  ADDR_W  memory address.
- `m_wdata`  out  DATA_W  memory write data.
- `m_be`  out  DATA_W/8  memory byte enables.
- `m_ready`  in  1  memory accepts the request on the cycle `m_req && m_ready`.
- `m_rvalid`  in  1  response strobe; exactly one per accepted request, reads and writes.
- `m_rdata`  in  DATA_W  response data.
- `stall`  out  1  pipeline hold for data accesses.

## Operation
- FSM states: IDLE, REQ, RESP. An `owner` register (FETCH or DATA) records the granted requester.
- **IDLE**
  - Data wins if `d_req`, otherwise fetch wins if `if_req`.
  - The winner's `*_gnt` is driven combinationally high in this cycle.
  - At the edge, the arbiter captures addr/we/wdata/be and `owner`, then moves to REQ.
  - Fetch captures are forced to `we`=0 and `be`=all ones.
- **REQ**
  - `m_req`=1; `m_*` come from the captured registers and are stable.
  - When `m_ready`=1, move to RESP.
- **RESP**
  - `m_req`=0.
  - When `m_rvalid`=1, register `m_rdata` into the owner's `*_rdata` and pulse the owner's `*_rvalid` on the next cycle. Return to IDLE at the same edge.
- `m_rvalid` outside RESP is ignored.
- `*_rdata` holds its last value between responses. The non-owner's `*_rdata` is unchanged.
- `stall` = `d_req` | (state≠IDLE & owner==DATA), combinational.
- Reset, including mid-transaction:
  - state=IDLE, owner=FETCH, streak counter=0.
  - `m_req`=0, `m_we`=0, `m_addr`=0, `m_wdata`=0, `m_be`=0.
  - `if_rvalid`=`d_rvalid`=0, `if_rdata`=`d_rdata`=0.
  - `if_gnt`/`d_gnt` are low during `rst`.
  - A pending memory response is dropped.

## Timing
- Memory accepts at cycle 1 if `m_ready` is already high.
- Minimum latency, `*_req` at cycle 0 in IDLE: `*_gnt` cycle 0, `m_req` cycle 1, `m_rvalid` earliest cycle 2, `*_rvalid` cycle 3.
- The state is IDLE in the `*_rvalid` cycle. A new grant can happen in that cycle, giving back-to-back issue every 3 cycles at zero memory wait.
- If `d_req` and `if_req` are asserted together in IDLE, only `d_gnt` pulses (subject to fairness below).
- Holding `*_req` after `*_gnt` issues a second transaction; requesters must drop `*_req` the cycle after `*_gnt`.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined:
  - A saturating counter counts consecutive data grants made while `if_req`=1.
  - When the counter equals `MAX_DATA_STREAK` and `if_req`=1, fetch wins the next IDLE arbitration even if `d_req`=1.
  - The counter clears on any fetch grant, or on any data grant made with `if_req`=0.
- Undefined: strict data priority; no counter logic.

## Test plan
- Single fetch: `if_addr`=0x100, `m_ready`=1, `m_rvalid` one cycle after accept with 0x00000013 → `if_gnt` cycle 0, `m_req` cycle 1, `m_we`=0, `m_be`=0xF, `if_rvalid` cycle 3, `if_rdata`=0x13.
- Store: `d_we`=1, `d_addr`=0x2004, `d_wdata`=0xDEADBEEF, `d_be`=0x3, `m_ready` low for 2 cycles → `m_*` stable across the wait; `stall`=1 until `d_rvalid`; `d_rdata` unchanged.
- Simultaneous `if_req`+`d_req` → data first; fetch granted in the `d_rvalid` cycle; `if_rvalid` exactly 3 cycles later at zero wait.
- Reset in RESP, then a late `m_rvalid` → no `*_rvalid`, state IDLE, all outputs at their reset values.
- Fairness: `MEM_ARB_FAIRNESS_EN` defined, `MAX_DATA_STREAK`=4, `d_req` and `if_req` held continuously → exactly 4 data grants, then 1 fetch grant, repeating. With the macro undefined → fetch is never granted.
